// File: rtl/dm_cache_pkg.sv
// Shared constants for the direct-mapped write-through cache: FSM encodings and
// address-field widths derived from the LINES / WPL geometry.
package dm_cache_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_REFILL = 2'd1;
  localparam state_t S_WRITE  = 2'd2;

  function automatic int off_w(int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_w(int lines);
    return $clog2(lines);
  endfunction

  // Tag is everything above index and word offset; byte offset is dropped.
  function automatic int tag_w(int lines, int wpl);
    return ADDR_W - 2 - off_w(wpl) - idx_w(lines);
  endfunction
endpackage

// File: rtl/dm_cache_if.sv
// CPU memory-stage port and backing-memory word port of dm_cache.
interface dm_cache_if;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd;
  logic [3:0]  mem_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_array.sv
// Tag/valid/data storage: one byte-enabled write port, combinational read.
// Only valid bits are reset; tag and data contents survive reset.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WPL   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [idx_w(LINES)-1:0]    rd_idx,
  input  logic [off_w(WPL)-1:0]      rd_off,
  output logic                       rd_valid,
  output logic [tag_w(LINES,WPL)-1:0] rd_tag,
  output logic [DATA_W-1:0]          rd_word,
  input  logic                       wr_en,
  input  logic [idx_w(LINES)-1:0]    wr_idx,
  input  logic [off_w(WPL)-1:0]      wr_off,
  input  logic [3:0]                 wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       tag_we,
  input  logic [tag_w(LINES,WPL)-1:0] tag_in
);
  localparam int TAG_W = tag_w(LINES, WPL);

  logic [LINES-1:0]                valid;
  logic [TAG_W-1:0]                tags [LINES];
  logic [WPL-1:0][DATA_W-1:0]      data [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_word  = data[rd_idx][rd_off];

  always_ff @(posedge clk) begin
    if (!rst)        valid <= '0;
    else if (tag_we) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tag_we) tags[wr_idx] <= tag_in;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data[wr_idx][wr_off][b*8 +: 8] <= wr_data[b*8 +: 8];
  end
endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 with single-word refill port.
// Define DCACHE_STATS_EN to add saturating hit_cnt / miss_cnt load counters.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WPL   = 4
) (
  input  logic         clk,
  input  logic         rst,
  dm_cache_if.slave    cif
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);
  localparam int OFF_W = off_w(WPL);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WPL);

  state_t             state;
  logic [OFF_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid, hit, is_load, last;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_word;
  logic               wr_en, tag_we;
  logic [OFF_W-1:0]   wr_off;
  logic [3:0]         wr_be;
  logic [DATA_W-1:0]  wr_data;
  logic               unused;

  assign idx     = cif.cpu_addr[OFF_W+2 +: IDX_W];
  assign off     = cif.cpu_addr[2 +: OFF_W];
  assign tag     = cif.cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused  = ^cif.cpu_addr[1:0];
  assign hit     = rd_valid && (rd_tag == tag);
  assign is_load = (cif.cpu_we == 4'h0);
  assign last    = (cnt == OFF_W'(WPL-1));

  dm_cache_array #(.LINES(LINES), .WPL(WPL)) u_array (
    .clk, .rst,
    .rd_idx(idx), .rd_off(off), .rd_valid, .rd_tag, .rd_word,
    .wr_en, .wr_idx(idx), .wr_off, .wr_be, .wr_data,
    .tag_we, .tag_in(tag)
  );

  always_comb begin
    wr_en         = 1'b0;
    wr_off        = off;
    wr_be         = cif.cpu_we;
    wr_data       = cif.cpu_wdata;
    tag_we        = 1'b0;
    cif.cpu_stall = 1'b0;
    cif.mem_rd    = 1'b0;
    cif.mem_wr    = 4'h0;
    cif.mem_addr  = '0;
    cif.mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (cif.cpu_req) begin
          cif.cpu_stall = !is_load || !hit;
          // Store hits merge into the line on the same edge that enters WRITE.
          wr_en         = !is_load && hit;
        end
      end
      S_REFILL: begin
        cif.mem_rd    = 1'b1;
        cif.mem_addr  = {cif.cpu_addr[ADDR_W-1:OFF_W+2], cnt, 2'b00};
        wr_en         = cif.mem_ack;
        wr_off        = cnt;
        wr_be         = 4'hF;
        wr_data       = cif.mem_rdata;
        tag_we        = cif.mem_ack && last;
        cif.cpu_stall = !(cif.mem_ack && last);
      end
      S_WRITE: begin
        cif.mem_wr    = cif.cpu_we;
        cif.mem_addr  = {cif.cpu_addr[ADDR_W-1:2], 2'b00};
        cif.mem_wdata = cif.cpu_wdata;
        cif.cpu_stall = !cif.mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cif.cpu_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cif.cpu_req) begin
            if (!is_load)  state <= S_WRITE;
            else if (hit)  cif.cpu_rdata <= rd_word;
            else begin
              state <= S_REFILL;
              cnt   <= '0;
            end
          end
        end
        S_REFILL: begin
          if (cif.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= S_IDLE;
              cnt   <= '0;
              // The requested word is either arriving now or already in the array.
              cif.cpu_rdata <= (off == cnt) ? cif.mem_rdata : rd_word;
            end
          end
        end
        S_WRITE: if (cif.mem_ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic load_acc;
  assign load_acc = (state == S_IDLE) && cif.cpu_req && is_load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (load_acc && hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
      if (load_acc && !hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: stimulus queues expected results, a monitor
// compares load data, memory writes and queued observations against them.
module tb_dm_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_cache_if cif();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  dm_cache #(.LINES(16), .WPL(4)) dut (.clk(clk), .rst(rst), .cif(cif),
                                       .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  dm_cache #(.LINES(16), .WPL(4)) dut (.clk(clk), .rst(rst), .cif(cif));
`endif

  typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } obs_t;
  typedef struct { logic [15:0] a; logic [3:0] be; logic [31:0] d; } wr_t;

  logic [31:0] lq[$];
  wr_t         wq[$];
  obs_t        oq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          fin = 1'b0;
  int          late_tok = 0;

  function automatic void obs(input string n, input logic [31:0] a, input logic [31:0] e);
    oq.push_back('{n, a, e});
  endfunction

  // Backing memory: word i initialised to {16'h1234, byte address}; ack toggles.
  initial begin
    logic [31:0] mem [16384];
    int          late_done;
    late_done     = 0;
    cif.mem_ack   = 1'b0;
    cif.mem_rdata = '0;
    for (int i = 0; i < 16384; i++) mem[i] = {16'h1234, 16'(i * 4)};
    forever begin
      @(negedge clk);
      if (cif.mem_ack) cif.mem_ack = 1'b0;
      else if (late_tok != late_done) begin
        late_done     = late_tok;
        cif.mem_rdata = 32'hDEAD_BEEF;
        cif.mem_ack   = 1'b1;
      end else if (cif.mem_rd) begin
        cif.mem_rdata = mem[cif.mem_addr[15:2]];
        cif.mem_ack   = 1'b1;
      end else if (cif.mem_wr != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (cif.mem_wr[b]) mem[cif.mem_addr[15:2]][b*8 +: 8] = cif.mem_wdata[b*8 +: 8];
        cif.mem_ack = 1'b1;
      end
    end
  end

  // Monitor: samples handshakes just before each edge, checks just after it.
  initial begin
    bit ld_fire, st_fire;
    logic [15:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_data;
    forever begin
      @(negedge clk); #4;
      ld_fire = rst && cif.cpu_req && (cif.cpu_we == 4'h0) && !cif.cpu_stall;
      st_fire = rst && (cif.mem_wr != 4'h0) && cif.mem_ack;
      s_addr = cif.mem_addr; s_be = cif.mem_wr; s_data = cif.mem_wdata;
      @(posedge clk); #1;
      if (ld_fire) begin
        if (lq.size() > 0) chk("load_data", cif.cpu_rdata, lq.pop_front());
        else               chk("load_unexpected", 32'd0, 32'd1);
      end
      if (st_fire) begin
        if (wq.size() > 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("mem_wr_addr", 32'(s_addr), 32'(w.a));
          chk("mem_wr_be", 32'(s_be), 32'(w.be));
          chk("mem_wr_data", s_data, w.d);
        end else chk("store_unexpected", 32'd0, 32'd1);
      end
      while (oq.size() > 0) begin
        obs_t o;
        o = oq.pop_front();
        chk(o.nm, o.act, o.exp);
      end
      if (fin) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // One CPU access; returns once the completing edge has passed and req is dropped.
  task automatic op(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d,
                    input logic [31:0] exp, input int exp_rd);
    int          nrd, nst;
    logic [15:0] ra [8];
    logic [15:0] base;
    bit          ok;
    @(negedge clk); #1;
    cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = a; cif.cpu_wdata = d;
    if (we == 4'h0) lq.push_back(exp);
    else            wq.push_back('{{a[15:2], 2'b00}, we, d});
    nrd = 0; nst = 0; ok = 1'b0;
    for (int k = 0; k < 8; k++) ra[k] = '0;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (cif.mem_rd && cif.mem_ack) begin
        if (nrd < 8) ra[nrd] = cif.mem_addr;
        nrd++;
      end
      if (!cif.cpu_stall) begin ok = 1'b1; break; end
      nst++;
      @(negedge clk); #2;
    end
    base = {a[15:4], 4'h0};
    obs("op_done", 32'(ok), 32'd1);
    obs("mem_rd_count", 32'(nrd), 32'(exp_rd));
    for (int k = 0; k < exp_rd && k < nrd && k < 8; k++)
      obs("mem_rd_addr", 32'(ra[k]), 32'(base + 16'(4 * k)));
    obs("stalled", 32'(nst > 0), 32'((we != 4'h0) || (exp_rd > 0)));
    if (ok) begin @(posedge clk); #1; end
    cif.cpu_req = 1'b0; cif.cpu_we = 4'h0;
  endtask

  initial begin
    int nacks;
    bit hit3;
    rst = 1'b0;
    cif.cpu_req = 1'b0; cif.cpu_we = 4'h0; cif.cpu_addr = '0; cif.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #2;
    obs("rst_rdata", cif.cpu_rdata, 32'd0);
    obs("rst_stall", 32'(cif.cpu_stall), 32'd0);
    obs("rst_mem_rd", 32'(cif.mem_rd), 32'd0);
    obs("rst_mem_wr", 32'(cif.mem_wr), 32'd0);
    obs("rst_mem_addr", 32'(cif.mem_addr), 32'd0);
    obs("rst_mem_wdata", cif.mem_wdata, 32'd0);
    rst = 1'b1;

    op(16'h0104, 4'h0, '0, 32'h1234_0104, 4);            // cold miss, full refill
    op(16'h0108, 4'h0, '0, 32'h1234_0108, 0);            // hit in same line
    op(16'h0104, 4'h3, 32'hAABB_CCDD, '0, 0);            // store hit, low half
    op(16'h0104, 4'h0, '0, 32'h1234_CCDD, 0);            // merged data, no refill
    op(16'h2000, 4'hF, 32'h1122_3344, '0, 0);            // store miss: no allocate
    op(16'h2000, 4'h0, '0, 32'h1122_3344, 4);            // still a miss
    op(16'h0104, 4'h0, '0, 32'h1234_CCDD, 4);            // evicted by 0x2000
    op(16'h0204, 4'h0, '0, 32'h1234_0204, 4);            // conflicting tag
    op(16'h0104, 4'h0, '0, 32'h1234_CCDD, 4);            // evicted again

    repeat (3) @(negedge clk);
    #2;
    obs("idle_rdata_hold", cif.cpu_rdata, 32'h1234_CCDD);
    obs("idle_mem_rd", 32'(cif.mem_rd), 32'd0);

    // Reset lands on the third refill ack.
    @(negedge clk); #1;
    cif.cpu_req = 1'b1; cif.cpu_we = 4'h0; cif.cpu_addr = 16'h0304;
    nacks = 0; hit3 = 1'b0;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (cif.mem_rd && cif.mem_ack) nacks++;
      if (nacks == 3) begin rst = 1'b0; cif.cpu_req = 1'b0; hit3 = 1'b1; break; end
      @(negedge clk); #2;
    end
    obs("abort_reached", 32'(hit3), 32'd1);
    @(posedge clk); #1;
    obs("abort_stall", 32'(cif.cpu_stall), 32'd0);
    obs("abort_mem_rd", 32'(cif.mem_rd), 32'd0);
    obs("abort_rdata", cif.cpu_rdata, 32'd0);
    obs("abort_mem_addr", 32'(cif.mem_addr), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    late_tok++;
    repeat (3) @(negedge clk);
    #2;
    obs("late_ack_rdata", cif.cpu_rdata, 32'd0);
    obs("late_ack_stall", 32'(cif.cpu_stall), 32'd0);
    obs("late_ack_mem_rd", 32'(cif.mem_rd), 32'd0);

    op(16'h0304, 4'h0, '0, 32'h1234_0304, 4);            // full refill after abort
    op(16'h030C, 4'h0, '0, 32'h1234_030C, 0);            // line now valid

    repeat (2) @(negedge clk);
    #2;
    obs("lq_drain", 32'(lq.size()), 32'd0);
    obs("wq_drain", 32'(wq.size()), 32'd0);
    repeat (2) @(negedge clk);
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 Parameter: LINES, 16, number of direct-mapped lines (power of two, 4..64).
REQ-002 Parameter: WPL, 4, 32-bit words per line (power of two, 2..8).
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 cpu_req  in  1  memory-stage access valid.
REQ-006 cpu_we  in  4  byte write enables; 0 = load, nonzero = store.
REQ-007 cpu_addr  in  16  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  in  32  store data.
REQ-009 cpu_rdata  out  32  load data, registered.
REQ-010 cpu_stall  out  1  freeze pipeline; request inputs held stable while high.
REQ-011 mem_rd  out  1  backing-memory word read request.
REQ-012 mem_wr  out  4  backing-memory byte write enables.
REQ-013 mem_addr  out  16  backing-memory word address (bits [1:0] = 0).
REQ-014 mem_wdata  out  32  backing-memory write data.
REQ-015 mem_rdata  in  32  backing-memory read data, valid with mem_ack.
REQ-016 mem_ack  in  1  one-cycle completion of current mem_rd or mem_wr.

Function
REQ-017 Organisation: direct-mapped; per line one valid bit, one tag, WPL data words; index = addr[log2(WPL)+2 +: log2(LINES)], tag = remaining upper bits.
REQ-018 Policy: write-through, no-write-allocate; hit store merges enabled bytes into line and forwards the same bytes to memory.
REQ-019 States: IDLE, REFILL, WRITE; reset state IDLE.
REQ-020 IDLE, load hit: cpu_stall low; cpu_rdata = hit word on next edge (one-cycle latency, matching SRAM read timing).
REQ-021 IDLE, load miss: cpu_stall high same cycle (combinational); go REFILL, word counter = 0.
REQ-022 REFILL: issue WPL sequential reads, words 0..WPL-1 of line; mem_rd high, mem_addr = line base + 4*counter; each mem_ack writes word, increments counter.
REQ-023 REFILL complete (last ack): set valid, write tag, register requested word into cpu_rdata, return IDLE; cpu_stall drops in that cycle.
REQ-024 IDLE, any store: cpu_stall high; go WRITE; hit line updated on entry edge; miss leaves cache untouched.
REQ-025 WRITE: mem_wr = cpu_we, mem_addr = word address, mem_wdata = cpu_wdata held until mem_ack; on ack return IDLE, cpu_stall low that cycle.
REQ-026 mem_rd and mem_wr never both asserted; both zero in IDLE.
REQ-027 mem_ack outside REFILL/WRITE ignored.
REQ-028 cpu_req low in IDLE: no state change, cpu_rdata holds.
REQ-029 Load directly after store to same word hits updated data (no stale read).
REQ-030 Counter wraps only by exit; never exceeds WPL-1.

Reset
REQ-031 rst low at an edge: state IDLE, all valid bits 0, counter 0, cpu_rdata 0, cpu_stall 0, mem_rd 0, mem_wr 0, mem_addr 0, mem_wdata 0; data/tag arrays not cleared.
REQ-032 Reset mid-REFILL or mid-WRITE aborts the transaction; partial line stays invalid; late mem_ack ignored.

Configuration
REQ-033 Macro DCACHE_STATS_EN defined: adds outputs hit_cnt (32) and miss_cnt (32), incremented per accepted IDLE load hit/miss, cleared by reset, saturating at all-ones.
REQ-034 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-035 Shared package dm_cache_pkg: state enum, address-field width constants derived from LINES/WPL.
REQ-036 One sub-module dm_cache_array: tag/valid/data storage, single write port with byte enables, combinational read.

Verification
REQ-037 Cold load 0x0104 -> stall high WPL reads at 0x0100..0x010C with ack each next cycle, cpu_rdata = mem word at 0x0104, valid set.
REQ-038 Repeat load 0x0108 after REQ-037 -> no stall, no mem_rd, cpu_rdata = word 0x0108 next cycle.
REQ-039 Store we=4'b0011 data 0xAABBCCDD to 0x0104 (hit) -> mem_wr=0011 addr 0x0104 until ack; next load returns upper bytes original, low half 0xCCDD.
REQ-040 Store miss to 0x2000 -> mem write issued, line 0x2000 stays invalid; load 0x2000 then misses.
REQ-041 Load conflicting tag same index (0x0104 then 0x0104+LINES*WPL*4) -> second refills and evicts; reload 0x0104 misses again.
REQ-042 rst low during third REFILL ack -> IDLE, stall 0, line invalid; late ack ignored; load again performs full refill.
